// File: rtl/bus_pkg.sv
// Shared types and widths for the 8086-style bus master and its wait-state timer.
`timescale 1ns/1ps
package bus_pkg;
   localparam int unsigned BUS_ADDR_W = 20;
   localparam int unsigned BUS_DATA_W = 8;
   localparam int unsigned WAIT_CNT_W = 8;

   typedef enum logic [5:0] {
      IDLE = 6'b000001,
      T1   = 6'b000010,
      T2   = 6'b000100,
      T3   = 6'b001000,
      TW   = 6'b010000,
      T4   = 6'b100000
   } bus_state_t;

   typedef struct packed {
      logic                  write;
      logic                  iom;
      logic [BUS_ADDR_W-1:0] addr;
      logic [BUS_DATA_W-1:0] wdata;
   } bus_req_t;
endpackage

// File: rtl/bus_wait_timer.sv
// Counts inserted wait states and flags when the limit has been reached.
`timescale 1ns/1ps
module bus_wait_timer
   import bus_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [WAIT_CNT_W-1:0] max_wait,
   output logic                  expired
);

   logic [WAIT_CNT_W-1:0] count;

   // expired tracks (count == max_wait) one register stage ahead of use
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         count   <= '0;
         expired <= 1'b0;
      end else if (clear) begin
         count   <= '0;
         expired <= 1'b0;
      end else if (enable) begin
         count   <= count + WAIT_CNT_W'(1);
         expired <= ((count + WAIT_CNT_W'(1)) == max_wait);
      end
   end

endmodule

// File: rtl/bus_master_8086.sv
// Minimum-mode 8086-style bus initiator: runs one byte transfer per request
// as T1-T2-T3-(TW)*-T4 and reports completion on a one-cycle response strobe.
`timescale 1ns/1ps
module bus_master_8086
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_W   = BUS_ADDR_W,
   parameter int unsigned DATA_W   = BUS_DATA_W,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_iom,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   input  logic              READY,
   output logic              ALE,
   output logic              IOM,
   output logic              RD,
   output logic              WR,
   output logic [ADDR_W-1:0] Address,
   inout  logic [DATA_W-1:0] Data
);

   bus_state_t state;
   bus_req_t   hold;
   logic       data_oe;
   logic       expired;
   logic       accept_c;
   logic       strobe_phase_c;
   logic       timeout_c;
   logic       done_c;

   assign accept_c       = req_valid & req_ready;
   assign strobe_phase_c = (state == T3) || (state == TW);
   assign timeout_c      = (state == TW) && !READY && expired;
   assign done_c         = strobe_phase_c && (READY || timeout_c);

   // Address and space select come straight from the held request so they
   // stay put from T1 through T4 and keep their last value while idle.
   assign Address = ADDR_W'(hold.addr);
   assign IOM     = hold.iom;
   assign Data    = data_oe ? DATA_W'(hold.wdata) : {DATA_W{1'bz}};

   bus_wait_timer u_wait_timer (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .clear    (accept_c),
      .enable   (strobe_phase_c && !done_c),
      .max_wait (WAIT_CNT_W'(MAX_WAIT)),
      .expired  (expired)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         hold      <= '0;
         ALE       <= 1'b0;
         RD        <= 1'b1;
         WR        <= 1'b1;
         data_oe   <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE, T4: begin
               if (accept_c) begin
                  state     <= T1;
                  hold      <= '{write: req_write,
                                 iom:   req_iom,
                                 addr:  BUS_ADDR_W'(req_addr),
                                 wdata: BUS_DATA_W'(req_wdata)};
                  ALE       <= 1'b1;
                  req_ready <= 1'b0;
                  rsp_err   <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            T1: begin
               state <= T2;
               ALE   <= 1'b0;
               if (hold.write) begin
                  WR      <= 1'b0;
                  data_oe <= 1'b1;
               end else begin
                  RD <= 1'b0;
               end
            end
            T2: state <= T3;
            T3, TW: begin
               if (done_c) begin
                  state     <= T4;
                  RD        <= 1'b1;
                  WR        <= 1'b1;
                  data_oe   <= 1'b0;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= timeout_c;
                  rsp_rdata <= (hold.write || timeout_c) ? '0 : Data;
               end else begin
                  state <= TW;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_8086.sv
// Self-checking bench: responder memory on the bus plus a transaction-level model.
`timescale 1ns/1ps
module tb_bus_master_8086;

   localparam int         MAXW = 4;
   localparam logic [7:0] PULL = 8'hFF;

   logic        CLK, RESET_N;
   logic        req_valid, req_ready, req_write, req_iom;
   logic [19:0] req_addr, Address;
   logic [7:0]  req_wdata, rsp_rdata, rd_val;
   logic        rsp_valid, rsp_err, READY, ALE, IOM, RD, WR;
   wire  [7:0]  Data;

   int checks = 0;
   int errors = 0;
   int viol   = 0;

   int          obs_lat, obs_ale, obs_rdlo, obs_wrlo, obs_bad;
   logic [7:0]  obs_rdata;
   logic        obs_err;

   logic [7:0] bus_mem   [int];
   logic [7:0] model_mem [int];

   bus_master_8086 #(.ADDR_W(20), .DATA_W(8), .MAX_WAIT(MAXW)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_iom(req_iom), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .READY(READY), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
      .Address(Address), .Data(Data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] init_byte(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] model_read(input logic [19:0] a);
      return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_byte(a);
   endfunction

   // Responder: drives read data while RD is low, latches writes while WR is low.
   assign Data = (RD === 1'b0) ? rd_val : 8'hzz;
   for (genvar i = 0; i < 8; i++) begin : g_pull
      pullup pu (Data[i]);
   end
   always @(negedge CLK)
      rd_val = bus_mem.exists(int'(Address)) ? bus_mem[int'(Address)] : init_byte(Address);
   always @(posedge CLK)
      if (WR === 1'b0) bus_mem[int'(Address)] = Data;

   always @(negedge CLK) begin
      if (RESET_N === 1'b1) begin
         if (RD === 1'b0 && WR === 1'b0) viol++;
         if (ALE === 1'b1 && (RD === 1'b0 || WR === 1'b0)) viol++;
      end
   end

   // Driver: issue one request, hold READY low for 'waits' strobe-phase cycles, record what the bus did.
   task automatic drive_txn(input logic w, input logic iom, input logic [19:0] a,
                            input logic [7:0] d, input int waits);
      bit done;
      obs_lat = -1; obs_rdata = 8'hxx; obs_err = 1'bx;
      obs_ale = 0; obs_rdlo = 0; obs_wrlo = 0; obs_bad = 0;
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) begin
         @(posedge CLK); #1;
      end
      req_valid = 1'b1; req_write = w; req_iom = iom; req_addr = a; req_wdata = d;
      @(posedge CLK); #1;
      req_valid = 1'b0; req_write = 1'($urandom); req_iom = 1'($urandom);
      req_addr = 20'($urandom); req_wdata = 8'($urandom);
      done = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         if (ALE === 1'b1) obs_ale++;
         if (RD === 1'b0) obs_rdlo++;
         if (WR === 1'b0) obs_wrlo++;
         if (IOM !== iom || Address !== a) obs_bad++;
         if (w && WR === 1'b0 && Data !== d) obs_bad++;
         if ((ALE === 1'b1 || rsp_valid === 1'b1) && Data !== PULL) obs_bad++;
         if (rsp_valid === 1'b1) begin
            obs_lat = k; obs_rdata = rsp_rdata; obs_err = rsp_err;
            if (req_ready !== 1'b1 || RD !== 1'b1 || WR !== 1'b1) obs_bad++;
            done = 1'b1;
         end else begin
            if (req_ready !== 1'b0) obs_bad++;
            READY = (k >= 3) ? (k - 3 >= waits) : 1'($urandom);
            @(posedge CLK); #1;
         end
      end
      if (w) model_mem[int'(a)] = d;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_iom = 1'b0;
      req_addr = '0; req_wdata = '0; READY = 1'b1;
      #12;
      checks++;
      if ({ALE, RD, WR, IOM, req_ready, rsp_valid, rsp_err} !== 7'b0110100) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected %b", {ALE, RD, WR, IOM, req_ready, rsp_valid, rsp_err}, 7'b0110100);
      end
      checks++;
      if (Address !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", Address); end
      checks++;
      if (rsp_rdata !== 8'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
      checks++;
      if (Data !== PULL) begin errors++; $display("FAIL reset_data_released: got %h expected %h", Data, PULL); end
      RESET_N = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_read_zero_wait();
      bus_mem[int'(20'h00010)] = 8'hA5;
      model_mem[int'(20'h00010)] = 8'hA5;
      drive_txn(1'b0, 1'b0, 20'h00010, 8'h00, 0);
      checks++; if (obs_lat !== 4) begin errors++; $display("FAIL rd0_latency: got %0d expected 4", obs_lat); end
      checks++; if (obs_rdata !== 8'hA5) begin errors++; $display("FAIL rd0_rdata: got %h expected a5", obs_rdata); end
      checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL rd0_err: got %b expected 0", obs_err); end
      checks++; if (obs_ale !== 1) begin errors++; $display("FAIL rd0_ale_cycles: got %0d expected 1", obs_ale); end
      checks++; if (obs_rdlo !== 2 || obs_wrlo !== 0) begin errors++; $display("FAIL rd0_strobes: got rd %0d wr %0d expected rd 2 wr 0", obs_rdlo, obs_wrlo); end
      checks++; if (obs_bad !== 0) begin errors++; $display("FAIL rd0_bus_rules: got %0d bad cycles expected 0", obs_bad); end
   endtask

   task automatic test_write();
      drive_txn(1'b1, 1'b0, 20'h00020, 8'h3C, 0);
      checks++; if (obs_lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", obs_lat); end
      checks++; if (obs_rdata !== 8'h00 || obs_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got rdata %h err %b expected 00 0", obs_rdata, obs_err); end
      checks++; if (obs_wrlo !== 2 || obs_rdlo !== 0) begin errors++; $display("FAIL wr_strobes: got wr %0d rd %0d expected wr 2 rd 0", obs_wrlo, obs_rdlo); end
      checks++; if (obs_bad !== 0) begin errors++; $display("FAIL wr_bus_rules: got %0d bad cycles expected 0", obs_bad); end
      drive_txn(1'b0, 1'b0, 20'h00020, 8'h00, 0);
      checks++; if (obs_rdata !== 8'h3C) begin errors++; $display("FAIL wr_readback: got %h expected 3c", obs_rdata); end
   endtask

   task automatic test_wait_states();
      bus_mem[int'(20'h00030)] = 8'h5A;
      model_mem[int'(20'h00030)] = 8'h5A;
      drive_txn(1'b0, 1'b1, 20'h00030, 8'h00, 3);
      checks++; if (obs_lat !== 7) begin errors++; $display("FAIL ws_latency: got %0d expected 7", obs_lat); end
      checks++; if (obs_rdata !== 8'h5A || obs_err !== 1'b0) begin errors++; $display("FAIL ws_rsp: got rdata %h err %b expected 5a 0", obs_rdata, obs_err); end
      checks++; if (obs_rdlo !== 5) begin errors++; $display("FAIL ws_rd_low: got %0d expected 5", obs_rdlo); end
   endtask

   task automatic test_timeout();
      drive_txn(1'b0, 1'b0, 20'h00044, 8'h00, 1000);
      checks++; if (obs_lat !== 4 + MAXW) begin errors++; $display("FAIL to_latency: got %0d expected %0d", obs_lat, 4 + MAXW); end
      checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", obs_err); end
      checks++; if (obs_rdata !== 8'h00) begin errors++; $display("FAIL to_rdata: got %h expected 00", obs_rdata); end
      checks++; if (obs_rdlo !== 2 + MAXW) begin errors++; $display("FAIL to_rd_low: got %0d expected %0d", obs_rdlo, 2 + MAXW); end
      checks++; if (obs_bad !== 0) begin errors++; $display("FAIL to_bus_rules: got %0d bad cycles expected 0", obs_bad); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d, rd1, rd2;
      int unsigned ale_mask, rv_mask;
      logic rdy_t4;
      d = 8'($urandom); ale_mask = 0; rv_mask = 0; rdy_t4 = 1'b0; rd1 = 8'hxx; rd2 = 8'hxx;
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) begin
         @(posedge CLK); #1;
      end
      READY = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_iom = 1'b0; req_addr = 20'h00050; req_wdata = d;
      for (int k = 1; k <= 10; k++) begin
         @(posedge CLK); #1;
         if (ALE === 1'b1) ale_mask |= (32'd1 << k);
         if (rsp_valid === 1'b1) rv_mask |= (32'd1 << k);
         if (k == 1) req_write = 1'b0;
         if (k == 4) begin rdy_t4 = req_ready; rd1 = rsp_rdata; end
         if (k == 5) req_valid = 1'b0;
         if (k == 8) rd2 = rsp_rdata;
      end
      model_mem[int'(20'h00050)] = d;
      checks++; if (ale_mask !== 32'h22) begin errors++; $display("FAIL b2b_ale_cycles: got %h expected 22", ale_mask); end
      checks++; if (rv_mask !== 32'h110) begin errors++; $display("FAIL b2b_rsp_cycles: got %h expected 110", rv_mask); end
      checks++; if (rdy_t4 !== 1'b1) begin errors++; $display("FAIL b2b_ready_t4: got %b expected 1", rdy_t4); end
      checks++; if (rd1 !== 8'h00 || rd2 !== d) begin errors++; $display("FAIL b2b_rdata: got %h %h expected 00 %h", rd1, rd2, d); end
   endtask

   task automatic test_async_reset();
      int seen;
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) begin
         @(posedge CLK); #1;
      end
      READY = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_iom = 1'b1; req_addr = 20'h00777; req_wdata = 8'h00;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      checks++; if (RD !== 1'b0) begin errors++; $display("FAIL arst_rd_low_t3: got %b expected 0", RD); end
      #2 RESET_N = 1'b0;
      #1;
      checks++;
      if ({ALE, RD, WR, IOM, req_ready, rsp_valid} !== 6'b011010) begin
         errors++;
         $display("FAIL arst_ctrl: got %b expected %b", {ALE, RD, WR, IOM, req_ready, rsp_valid}, 6'b011010);
      end
      checks++; if (Address !== 20'h0) begin errors++; $display("FAIL arst_addr: got %h expected 0", Address); end
      seen = 0;
      repeat (3) begin
         @(posedge CLK); #1;
         if (rsp_valid !== 1'b0) seen++;
      end
      @(negedge CLK); RESET_N = 1'b1;
      repeat (2) begin
         @(posedge CLK); #1;
         if (rsp_valid !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL arst_no_rsp: got %0d strobes expected 0", seen); end
      drive_txn(1'b0, 1'b1, 20'h00777, 8'h00, 1);
      checks++;
      if (obs_lat !== 5 || obs_rdata !== model_read(20'h00777) || obs_err !== 1'b0) begin
         errors++;
         $display("FAIL arst_recover: got lat %0d rdata %h err %b expected 5 %h 0", obs_lat, obs_rdata, obs_err, model_read(20'h00777));
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic        w, iom, to;
         logic [19:0] a;
         logic [7:0]  d, exp_rdata;
         int          waits, tw, exp_lat;
         w = 1'($urandom); iom = 1'($urandom);
         a = 20'h00100 + 20'($urandom_range(0, 7));
         d = 8'($urandom); waits = $urandom_range(0, 6);
         to = (waits > MAXW);
         tw = to ? MAXW : waits;
         exp_lat = 4 + tw;
         exp_rdata = (w || to) ? 8'h00 : model_read(a);
         drive_txn(w, iom, a, d, waits);
         checks++;
         if (obs_lat !== exp_lat || obs_err !== to || obs_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL rnd%0d_rsp: got lat %0d err %b rdata %h expected %0d %b %h", n, obs_lat, obs_err, obs_rdata, exp_lat, to, exp_rdata);
         end
         checks++;
         if (obs_ale !== 1 || obs_rdlo !== (w ? 0 : exp_lat - 2) || obs_wrlo !== (w ? exp_lat - 2 : 0) || obs_bad !== 0) begin
            errors++;
            $display("FAIL rnd%0d_bus: got ale %0d rd %0d wr %0d bad %0d expected 1 %0d %0d 0", n, obs_ale, obs_rdlo, obs_wrlo, obs_bad,
                     w ? 0 : exp_lat - 2, w ? exp_lat - 2 : 0);
         end
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (viol !== 0) begin errors++; $display("FAIL strobe_overlap_rules: got %0d violations expected 0", viol); end
   endtask

   initial begin
      test_reset();
      test_read_zero_wait();
      test_write();
      test_wait_states();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      test_random();
      test_protocol();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
